// File: rtl/tmds_pkg.sv
// Shared TMDS link constants: control tokens, test pattern and link state type.
package tmds_pkg;

    localparam logic [9:0] TOKEN_00     = 10'b1101010100;
    localparam logic [9:0] TOKEN_01     = 10'b0010101011;
    localparam logic [9:0] TOKEN_10     = 10'b0101010100;
    localparam logic [9:0] TOKEN_11     = 10'b1010101011;
    localparam logic [9:0] TEST_PATTERN = 10'b0000011111;

    typedef enum logic [1:0] {
        WAIT_LOCK,
        RST_HOLD,
        SETTLE,
        ACTIVE
    } link_state_t;

    // Control token selected by {C1,C0}
    function automatic logic [9:0] ctrl_token(input logic [1:0] c);
        logic [9:0] tok;
        case (c)
            2'b00:   tok = TOKEN_00;
            2'b01:   tok = TOKEN_01;
            2'b10:   tok = TOKEN_10;
            default: tok = TOKEN_11;
        endcase
        return tok;
    endfunction

endpackage

// File: rtl/tmds_lock_filter.sv
// Two-flop synchronizer for the MMCM lock plus a consecutive-high qualifier.
module tmds_lock_filter #(
    parameter int LOCK_FILT = 4
) (
    input  logic PI_clk,
    input  logic reset,
    input  logic clk_locked,
    output logic lock_ok
);

    localparam int RUN_W = $clog2(LOCK_FILT + 1);

    logic             sync1;
    logic             sync2;
    logic [RUN_W-1:0] run_cnt;

    // run_cnt holds the number of earlier consecutive highs, so lock_ok
    // asserts on the LOCK_FILT-th high sample without an extra register stage.
    always_ff @(posedge PI_clk) begin
        if (reset) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            run_cnt <= '0;
        end else begin
            sync1 <= clk_locked;
            sync2 <= sync1;
            if (!sync2) begin
                run_cnt <= '0;
            end else if (run_cnt != RUN_W'(LOCK_FILT - 1)) begin
                run_cnt <= run_cnt + RUN_W'(1);
            end
        end
    end

    assign lock_ok = sync2 && (run_cnt == RUN_W'(LOCK_FILT - 1));

endmodule

// File: rtl/tmds_serdes_ctrl.sv
// TMDS serializer bring-up FSM and symbol output mux.
// Optional feature: define TMDS_TEST_PATTERN_EN to add the test_en input.
module tmds_serdes_ctrl
    import tmds_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int SETTLE_CYCLES = 8,
    parameter int LOCK_FILT     = 4
) (
    input  logic       PI_clk,
    input  logic       reset,
    input  logic       clk_locked,
    input  logic       de,
    input  logic       hsync,
    input  logic       vsync,
    input  logic [9:0] enc0,
    input  logic [9:0] enc1,
    input  logic [9:0] enc2,
`ifdef TMDS_TEST_PATTERN_EN
    input  logic       test_en,
`endif
    output logic       serdes_rst,
    output logic [9:0] PI_data0,
    output logic [9:0] PI_data1,
    output logic [9:0] PI_data2,
    output logic       link_up
);

    localparam int CNT_MAX = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    link_state_t      state;
    logic [CNT_W-1:0] cnt;
    logic             lock_ok;
    logic [9:0]       nxt0;
    logic [9:0]       nxt1;
    logic [9:0]       nxt2;

    tmds_lock_filter #(
        .LOCK_FILT(LOCK_FILT)
    ) u_lock_filter (
        .PI_clk    (PI_clk),
        .reset     (reset),
        .clk_locked(clk_locked),
        .lock_ok   (lock_ok)
    );

    always_ff @(posedge PI_clk) begin
        if (reset || !lock_ok) begin
            state      <= WAIT_LOCK;
            cnt        <= '0;
            serdes_rst <= 1'b1;
            link_up    <= 1'b0;
        end else begin
            case (state)
                WAIT_LOCK: begin
                    state      <= RST_HOLD;
                    cnt        <= '0;
                    serdes_rst <= 1'b1;
                    link_up    <= 1'b0;
                end
                RST_HOLD: begin
                    if (cnt == CNT_W'(RST_CYCLES - 1)) begin
                        state      <= SETTLE;
                        cnt        <= '0;
                        serdes_rst <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                SETTLE: begin
                    if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
                        state   <= ACTIVE;
                        cnt     <= '0;
                        link_up <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state      <= ACTIVE;
                    serdes_rst <= 1'b0;
                    link_up    <= 1'b1;
                end
            endcase
        end
    end

    // Gating with lock_ok drops the channels to token 00 on the same edge
    // that the FSM leaves ACTIVE, so no stale pixel follows lock loss.
    always_comb begin
        nxt0 = TOKEN_00;
        nxt1 = TOKEN_00;
        nxt2 = TOKEN_00;
        if (state == ACTIVE && lock_ok) begin
            if (de) begin
                nxt0 = enc0;
                nxt1 = enc1;
                nxt2 = enc2;
            end else begin
                nxt0 = ctrl_token({vsync, hsync});
            end
`ifdef TMDS_TEST_PATTERN_EN
            if (test_en) begin
                nxt0 = TEST_PATTERN;
                nxt1 = TEST_PATTERN;
                nxt2 = TEST_PATTERN;
            end
`endif
        end
    end

    always_ff @(posedge PI_clk) begin
        if (reset) begin
            PI_data0 <= TOKEN_00;
            PI_data1 <= TOKEN_00;
            PI_data2 <= TOKEN_00;
        end else begin
            PI_data0 <= nxt0;
            PI_data1 <= nxt1;
            PI_data2 <= nxt2;
        end
    end

endmodule

// File: tb/tb_tmds_serdes_ctrl.sv
// Self-checking bench for tmds_serdes_ctrl against a cycle-count reference model.
module tb_tmds_serdes_ctrl;

    localparam int RC = 16;
    localparam int SC = 8;
    localparam int LF = 4;
    localparam logic [9:0] T00 = 10'b1101010100;

    logic       PI_clk = 1'b0;
    logic       reset;
    logic       clk_locked;
    logic       de, hsync, vsync;
    logic [9:0] enc0, enc1, enc2;
`ifdef TMDS_TEST_PATTERN_EN
    logic       test_en;
`endif
    logic       serdes_rst;
    logic [9:0] PI_data0, PI_data1, PI_data2;
    logic       link_up;

    tmds_serdes_ctrl #(
        .RST_CYCLES   (RC),
        .SETTLE_CYCLES(SC),
        .LOCK_FILT    (LF)
    ) dut (
        .PI_clk    (PI_clk),
        .reset     (reset),
        .clk_locked(clk_locked),
        .de        (de),
        .hsync     (hsync),
        .vsync     (vsync),
        .enc0      (enc0),
        .enc1      (enc1),
        .enc2      (enc2),
`ifdef TMDS_TEST_PATTERN_EN
        .test_en   (test_en),
`endif
        .serdes_rst(serdes_rst),
        .PI_data0  (PI_data0),
        .PI_data1  (PI_data1),
        .PI_data2  (PI_data2),
        .link_up   (link_up)
    );

    always #5 PI_clk = ~PI_clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: lock history seen through two sample delays, the run of
    // consecutive qualified highs, and cycles elapsed since lock qualified.
    logic        m_h1 = 1'b0, m_h2 = 1'b0;
    int          m_run = 0;
    int          m_q = -1;
    logic [31:0] exp_v;
    logic [31:0] obs;
    assign obs = {serdes_rst, link_up, PI_data0, PI_data1, PI_data2};

    function automatic logic [9:0] tok(input logic c1, input logic c0);
        logic [9:0] t;
        case ({c1, c0})
            2'b00:   t = 10'b1101010100;
            2'b01:   t = 10'b0010101011;
            2'b10:   t = 10'b0101010100;
            default: t = 10'b1010101011;
        endcase
        return t;
    endfunction

    task automatic tick();
        logic       v;
        logic [9:0] e0, e1, e2;
        @(posedge PI_clk);
        if (reset) begin
            m_h1 = 1'b0; m_h2 = 1'b0; m_run = 0; m_q = -1;
        end else begin
            v = m_h2; m_h2 = m_h1; m_h1 = clk_locked;
            m_run = v ? m_run + 1 : 0;
            if (m_run < LF) m_q = -1;
            else if (m_q < RC + SC + 1) m_q++;
        end
        e0 = T00; e1 = T00; e2 = T00;
        if (!reset && m_q > RC + SC) begin
            if (de) begin e0 = enc0; e1 = enc1; e2 = enc2; end
            else e0 = tok(vsync, hsync);
`ifdef TMDS_TEST_PATTERN_EN
            if (test_en) begin e0 = 10'b0000011111; e1 = e0; e2 = e0; end
`endif
        end
        exp_v = {(m_q < RC), (m_q >= RC + SC), e0, e1, e2};
        @(negedge PI_clk);
    endtask

    task automatic rand_video();
        de = 1'($urandom); hsync = 1'($urandom); vsync = 1'($urandom);
        enc0 = 10'($urandom); enc1 = 10'($urandom); enc2 = 10'($urandom);
    endtask

    task automatic bring_up();
        reset = 1'b1; clk_locked = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick(); n_cmp++;
            if (obs !== exp_v) begin n_bad++; $display("FAIL bring_up_reset: got %h want %h", obs, exp_v); end
        end
        reset = 1'b0; clk_locked = 1'b1;
        for (int i = 0; i < 100 && !link_up; i++) begin
            rand_video(); tick(); n_cmp++;
            if (obs !== exp_v) begin n_bad++; $display("FAIL bring_up: got %h want %h", obs, exp_v); end
        end
        if (!link_up) begin
            n_cmp++; n_bad++;
            $display("FAIL bring_up_timeout: link_up=%b want 1", link_up);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; clk_locked = 1'b1;
        rand_video();
        for (int i = 0; i < 3; i++) begin
            tick(); n_cmp++;
            if (obs !== {1'b1, 1'b0, T00, T00, T00}) begin
                n_bad++; $display("FAIL reset_state: got %h want %h", obs, {1'b1, 1'b0, T00, T00, T00});
            end
        end
    endtask

    task automatic test_power_up();
        int fall = -1, rise = -1;
        reset = 1'b1; clk_locked = 1'b0;
        tick(); tick();
        reset = 1'b0; clk_locked = 1'b1;
        for (int k = 1; k <= 100 && rise < 0; k++) begin
            rand_video(); tick(); n_cmp++;
            if (obs !== exp_v) begin n_bad++; $display("FAIL power_up: got %h want %h", obs, exp_v); end
            if (fall < 0 && serdes_rst === 1'b0) fall = k;
            if (rise < 0 && link_up === 1'b1) rise = k;
        end
        n_cmp++;
        if (fall != 2 + LF + RC) begin n_bad++; $display("FAIL rst_fall_cycle: got %0d want %0d", fall, 2 + LF + RC); end
        n_cmp++;
        if (rise - fall != SC) begin n_bad++; $display("FAIL link_up_delay: got %0d want %0d", rise - fall, SC); end
    endtask

    task automatic test_lock_glitch();
        reset = 1'b1; clk_locked = 1'b0;
        tick(); tick();
        reset = 1'b0;
        for (int k = 0; k < 16; k++) begin
            clk_locked = (k < LF - 1);
            rand_video(); tick(); n_cmp++;
            if (obs !== {1'b1, 1'b0, T00, T00, T00} || obs !== exp_v) begin
                n_bad++; $display("FAIL lock_glitch: got %h want %h", obs, {1'b1, 1'b0, T00, T00, T00});
            end
        end
    endtask

    task automatic test_passthrough();
        bring_up();
        de = 1'b1; enc0 = 10'h2AA; enc1 = 10'($urandom); enc2 = 10'($urandom);
        tick(); n_cmp++;
        if (PI_data0 !== 10'h2AA) begin n_bad++; $display("FAIL passthrough_2aa: got %h want %h", PI_data0, 10'h2AA); end
        for (int i = 0; i < 40; i++) begin
            rand_video(); tick(); n_cmp++;
            if (obs !== exp_v) begin n_bad++; $display("FAIL passthrough_rand: got %h want %h", obs, exp_v); end
        end
    endtask

    task automatic test_blanking();
        de = 1'b0; hsync = 1'b1; vsync = 1'b0;
        tick(); n_cmp++;
        if ({PI_data0, PI_data1, PI_data2} !== {10'b0010101011, T00, T00}) begin
            n_bad++; $display("FAIL blank_hsync: got %h want %h", {PI_data0, PI_data1, PI_data2}, {10'b0010101011, T00, T00});
        end
        for (int c = 0; c < 4; c++) begin
            de = 1'b0; vsync = c[1]; hsync = c[0];
            enc0 = 10'($urandom); enc1 = 10'($urandom); enc2 = 10'($urandom);
            tick(); n_cmp++;
            if (obs !== exp_v) begin n_bad++; $display("FAIL blank_tokens: got %h want %h", obs, exp_v); end
        end
    endtask

    task automatic test_lock_loss();
        bring_up();
        clk_locked = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            rand_video(); de = 1'b1; tick(); n_cmp++;
            if (obs !== exp_v) begin n_bad++; $display("FAIL lock_loss: got %h want %h", obs, exp_v); end
            if (k == 3) begin
                n_cmp++;
                if (obs !== {1'b1, 1'b0, T00, T00, T00}) begin
                    n_bad++; $display("FAIL lock_loss_edge: got %h want %h", obs, {1'b1, 1'b0, T00, T00, T00});
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        bring_up();
        for (int k = 0; k < 2 + LF + RC + 4; k++) begin
            reset = (k == 0 || k == 2 + LF + RC + 2);
            rand_video(); tick(); n_cmp++;
            if (obs !== exp_v) begin n_bad++; $display("FAIL mid_reset: got %h want %h", obs, exp_v); end
            if (reset) begin
                n_cmp++;
                if (obs !== {1'b1, 1'b0, T00, T00, T00}) begin
                    n_bad++; $display("FAIL mid_reset_state: got %h want %h", obs, {1'b1, 1'b0, T00, T00, T00});
                end
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_random();
        bring_up();
        for (int i = 0; i < 1500; i++) begin
            if (clk_locked) clk_locked = ($urandom_range(0, 79) != 0);
            else clk_locked = ($urandom_range(0, 3) == 0);
            reset = ($urandom_range(0, 299) == 0);
`ifdef TMDS_TEST_PATTERN_EN
            test_en = ($urandom_range(0, 4) == 0);
`endif
            rand_video(); tick(); n_cmp++;
            if (obs !== exp_v) begin n_bad++; $display("FAIL random: got %h want %h", obs, exp_v); end
        end
        reset = 1'b0;
`ifdef TMDS_TEST_PATTERN_EN
        test_en = 1'b0;
`endif
    endtask

`ifdef TMDS_TEST_PATTERN_EN
    task automatic test_pattern();
        test_en = 1'b1;
        reset = 1'b1; clk_locked = 1'b0;
        tick(); tick();
        reset = 1'b0; clk_locked = 1'b1;
        for (int i = 0; i < 100 && !link_up; i++) begin
            rand_video(); tick(); n_cmp++;
            if (obs !== exp_v) begin n_bad++; $display("FAIL pattern_bringup: got %h want %h", obs, exp_v); end
            if (!serdes_rst && !link_up) begin
                n_cmp++;
                if ({PI_data0, PI_data1, PI_data2} !== {T00, T00, T00}) begin
                    n_bad++; $display("FAIL pattern_settle: got %h want %h", {PI_data0, PI_data1, PI_data2}, {T00, T00, T00});
                end
            end
        end
        for (int i = 0; i < 8; i++) begin
            rand_video(); tick(); n_cmp++;
            if ({link_up, PI_data0, PI_data1, PI_data2} !== {1'b1, 10'b0000011111, 10'b0000011111, 10'b0000011111}) begin
                n_bad++; $display("FAIL pattern_active: got %h want %h", {link_up, PI_data0, PI_data1, PI_data2},
                                  {1'b1, 10'b0000011111, 10'b0000011111, 10'b0000011111});
            end
        end
        test_en = 1'b0;
    endtask
`endif

    initial begin
        reset = 1'b1; clk_locked = 1'b0;
        de = 1'b0; hsync = 1'b0; vsync = 1'b0;
        enc0 = '0; enc1 = '0; enc2 = '0;
`ifdef TMDS_TEST_PATTERN_EN
        test_en = 1'b0;
`endif
        test_reset();
        test_power_up();
        test_lock_glitch();
        test_passthrough();
        test_blanking();
        test_lock_loss();
        test_mid_reset();
`ifdef TMDS_TEST_PATTERN_EN
        test_pattern();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
